branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 82 ++++++++
 tb/tb_branch_predictor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped 8-entry branch predictor: 2-bit saturating direction
// counters plus a branch target buffer. Lookup is combinational from the
// fetch PC; updates are written at the decode-stage PC on a rising edge.
module branch_predictor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] PC_curr,
    input  logic [15:0] IF_ID_PC_curr,
    input  logic        wen_BHT,
    input  logic        wen_BTB,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    output logic        predicted_taken,
    output logic [15:0] predicted_target
);

    localparam int ENTRIES = 8;

    // Table storage, one element per entry.
    logic [ENTRIES-1:0]       r_valid;
    logic [ENTRIES-1:0][11:0] r_tag;
    logic [ENTRIES-1:0][1:0]  r_cnt;
    logic [ENTRIES-1:0][15:0] r_tgt;

    logic [2:0]  w_lidx;
    logic        w_lhit;
    logic [2:0]  w_uidx;
    logic        w_uhit;
    logic        w_upd;
    logic [15:0] w_pc_next;

    assign w_lidx    = PC_curr[3:1];
    assign w_uidx    = IF_ID_PC_curr[3:1];
    assign w_pc_next = PC_curr + 16'd2;

    // Lookup: rst_n is folded in so the output drops the instant reset
    // asserts, independent of when the storage clear settles.
    always_comb begin
        w_lhit           = rst_n && r_valid[w_lidx] && (r_tag[w_lidx] == PC_curr[15:4]);
        predicted_taken  = w_lhit && r_cnt[w_lidx][1];
        predicted_target = w_lhit ? r_tgt[w_lidx] : w_pc_next;
    end

    // Update-side hit detection; wen_BTB alone never writes the table.
    always_comb begin
        w_upd  = enable && wen_BHT;
        w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == IF_ID_PC_curr[15:4]);
    end

    // Table write: saturating counter update on hit, full allocate on miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= 12'h000;
                r_cnt[i]   <= 2'b01;
                r_tgt[i]   <= 16'h0000;
            end
        end else if (w_upd) begin
            if (w_uhit) begin
                if (actual_taken) begin
                    if (r_cnt[w_uidx] != 2'b11)
                        r_cnt[w_uidx] <= r_cnt[w_uidx] + 2'd1;
                end else begin
                    if (r_cnt[w_uidx] != 2'b00)
                        r_cnt[w_uidx] <= r_cnt[w_uidx] - 2'd1;
                end
                if (wen_BTB)
                    r_tgt[w_uidx] <= actual_target;
            end else begin
                // Miss or alias: evict and start at the weak state in the
                // resolved direction; the target is always captured.
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= IF_ID_PC_curr[15:4];
                r_cnt[w_uidx]   <= actual_taken ? 2'b10 : 2'b01;
                r_tgt[w_uidx]   <= actual_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: lookup expectations are queued
// when the PC is driven and popped when the output is sampled.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] PC_curr;
    logic [15:0] IF_ID_PC_curr;
    logic        wen_BHT;
    logic        wen_BTB;
    logic        actual_taken;
    logic [15:0] actual_target;
    logic        predicted_taken;
    logic [15:0] predicted_target;

    int total = 0;
    int bad   = 0;
    logic [16:0] sb_q[$];

    branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .PC_curr          (PC_curr),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .wen_BHT          (wen_BHT),
        .wen_BTB          (wen_BTB),
        .actual_taken     (actual_taken),
        .actual_target    (actual_target),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target)
    );

    always #5 clk = ~clk;

    // One update cycle: drive at negedge, let the posedge write, release.
    task automatic do_update(input logic [15:0] pc, input logic en, input logic bht,
                             input logic btb, input logic tk, input logic [15:0] tgt);
        @(negedge clk);
        IF_ID_PC_curr = pc; enable = en; wen_BHT = bht; wen_BTB = btb;
        actual_taken = tk; actual_target = tgt;
        @(posedge clk);
        #1;
        wen_BHT = 1'b0; wen_BTB = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] pcs[$];
        logic [16:0] ex[$];
        logic [16:0] got, e;
        enable = 1'b1; wen_BHT = 1'b0; wen_BTB = 1'b0; actual_taken = 1'b0;
        actual_target = 16'h0; IF_ID_PC_curr = 16'h0; PC_curr = 16'h0;
        rst_n = 1'b0;
        #12;
        pcs = '{16'h0010, 16'hFFFE, 16'h0024};
        ex  = '{{1'b0, 16'h0012}, {1'b0, 16'h0000}, {1'b0, 16'h0026}};
        for (int i = 0; i < pcs.size(); i++) begin
            PC_curr = pcs[i];
            sb_q.push_back(ex[i]);
            #1;
            got = {predicted_taken, predicted_target};
            e = sb_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got %h want %h", i, got, e);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_allocate();
        logic [15:0] pcs[$];
        logic [16:0] ex[$];
        logic [16:0] got, e;
        do_update(16'h0024, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0100);
        pcs = '{16'h0024, 16'h0025, 16'h0124, 16'h0026};
        ex  = '{{1'b1, 16'h0100}, {1'b1, 16'h0100}, {1'b0, 16'h0126}, {1'b0, 16'h0028}};
        for (int i = 0; i < pcs.size(); i++) begin
            PC_curr = pcs[i];
            sb_q.push_back(ex[i]);
            #1;
            got = {predicted_taken, predicted_target};
            e = sb_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL allocate[%0d]: got %h want %h", i, got, e);
            end
        end
    endtask

    // Counter walk: 10 -> 11 (saturate) -> 10 -> 01 -> 00 (saturate) -> 01 -> 10 -> 11.
    task automatic test_saturation();
        logic        tk[$];
        logic [16:0] ex[$];
        logic [16:0] got, e;
        tk = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ex = '{{1'b1, 16'h0100}, {1'b1, 16'h0100}, {1'b1, 16'h0100}, {1'b1, 16'h0100},
               {1'b0, 16'h0100}, {1'b0, 16'h0100}, {1'b0, 16'h0100}, {1'b0, 16'h0100},
               {1'b1, 16'h0100}, {1'b1, 16'h0100}};
        PC_curr = 16'h0024;
        for (int i = 0; i < tk.size(); i++) begin
            do_update(16'h0024, 1'b1, 1'b1, 1'b0, tk[i], 16'hDEAD);
            sb_q.push_back(ex[i]);
            #1;
            got = {predicted_taken, predicted_target};
            e = sb_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL saturation[%0d]: got %h want %h", i, got, e);
            end
        end
    endtask

    // Target write on hit only with wen_BTB; wen_BTB without wen_BHT is ignored.
    task automatic test_btb();
        logic [16:0] got, e;
        PC_curr = 16'h0024;
        do_update(16'h0024, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0300);
        sb_q.push_back({1'b1, 16'h0300});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL btb_write: got %h want %h", got, e); end
        do_update(16'h0024, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0400);
        sb_q.push_back({1'b1, 16'h0300});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL btb_only_ignored: got %h want %h", got, e); end
        do_update(16'h0034, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0400);
        PC_curr = 16'h0034;
        sb_q.push_back({1'b0, 16'h0036});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL btb_only_no_alloc: got %h want %h", got, e); end
    endtask

    // Frozen table while enable=0, then no bypass on a same-index update edge.
    task automatic test_stall();
        logic [16:0] got, e;
        PC_curr = 16'h0024;
        for (int i = 0; i < 5; i++)
            do_update(16'h0024, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0999);
        sb_q.push_back({1'b1, 16'h0300});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL stall_frozen: got %h want %h", got, e); end
        // One not-taken from strong-taken must still predict taken.
        do_update(16'h0024, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0999);
        sb_q.push_back({1'b1, 16'h0300});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL stall_counter_kept: got %h want %h", got, e); end
        // Same-index lookup during the update cycle.
        @(negedge clk);
        IF_ID_PC_curr = 16'h0024; enable = 1'b1; wen_BHT = 1'b1; wen_BTB = 1'b1;
        actual_taken = 1'b1; actual_target = 16'h0500;
        sb_q.push_back({1'b1, 16'h0300});
        #3;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL no_bypass_before_edge: got %h want %h", got, e); end
        sb_q.push_back({1'b1, 16'h0500});
        @(posedge clk);
        #1;
        wen_BHT = 1'b0; wen_BTB = 1'b0;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL visible_after_edge: got %h want %h", got, e); end
    endtask

    // 0x0024 and 0x0034 share index 2; not-taken allocate lands at counter 01.
    task automatic test_alias();
        logic [15:0] pcs[$];
        logic [16:0] ex[$];
        logic [16:0] got, e;
        do_update(16'h0034, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0700);
        pcs = '{16'h0024, 16'h0034};
        ex  = '{{1'b0, 16'h0026}, {1'b0, 16'h0700}};
        for (int i = 0; i < pcs.size(); i++) begin
            PC_curr = pcs[i];
            sb_q.push_back(ex[i]);
            #1;
            got = {predicted_taken, predicted_target};
            e = sb_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL alias[%0d]: got %h want %h", i, got, e);
            end
        end
        do_update(16'h0034, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0777);
        do_update(16'h1002, 1'b1, 1'b1, 1'b1, 1'b1, 16'h2000);
        pcs = '{16'h0034, 16'h1002, 16'h0002};
        ex  = '{{1'b1, 16'h0700}, {1'b1, 16'h2000}, {1'b0, 16'h0004}};
        for (int i = 0; i < pcs.size(); i++) begin
            PC_curr = pcs[i];
            sb_q.push_back(ex[i]);
            #1;
            got = {predicted_taken, predicted_target};
            e = sb_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL alias_after[%0d]: got %h want %h", i, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] got, e;
        do_update(16'h0024, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0100);
        PC_curr = 16'h0024;
        sb_q.push_back({1'b1, 16'h0100});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL pre_reset: got %h want %h", got, e); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.push_back({1'b0, 16'h0026});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL async_reset_drop: got %h want %h", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        PC_curr = 16'h1002;
        sb_q.push_back({1'b0, 16'h1004});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_cleared_other: got %h want %h", got, e); end
        PC_curr = 16'h0024;
        sb_q.push_back({1'b0, 16'h0026});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL reset_cleared_0024: got %h want %h", got, e); end
    endtask

    // Update driven together with reset release lands on the first edge.
    task automatic test_first_update();
        logic [16:0] got, e;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        IF_ID_PC_curr = 16'h0048; enable = 1'b1; wen_BHT = 1'b1; wen_BTB = 1'b0;
        actual_taken = 1'b1; actual_target = 16'h0A00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wen_BHT = 1'b0;
        PC_curr = 16'h0048;
        sb_q.push_back({1'b1, 16'h0A00});
        #1;
        got = {predicted_taken, predicted_target}; e = sb_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL first_update: got %h want %h", got, e); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_btb();
        test_stall();
        test_alias();
        test_async_reset();
        test_first_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
